// File: rtl/turn_arbiter_if.sv
// Player-side move requests and the point-drive/status bundle of turn_arbiter.
// master = player/stimulus side, slave = the arbiter.
interface turn_arbiter_if;
    logic       start;
    logic [1:0] req;
    logic [2:0] xMove0;
    logic [2:0] yMove0;
    logic [2:0] xMove1;
    logic [2:0] yMove1;
    logic       pt_rst;
    logic [1:0] pt_en;
    logic [1:0] pt_update;
    logic [2:0] xMove;
    logic [2:0] yMove;
    logic [1:0] grant;
    logic       turn;
    logic [4:0] turn_cnt;
    logic       collide;
    logic [2:0] x0;
    logic [2:0] y0;
    logic [2:0] x1;
    logic [2:0] y1;
    logic       done;

    modport master (
        output start, req, xMove0, yMove0, xMove1, yMove1,
        input  pt_rst, pt_en, pt_update, xMove, yMove, grant, turn, turn_cnt,
               collide, x0, y0, x1, y1, done
    );

    modport slave (
        input  start, req, xMove0, yMove0, xMove1, yMove1,
        output pt_rst, pt_en, pt_update, xMove, yMove, grant, turn, turn_cnt,
               collide, x0, y0, x1, y1, done
    );
endinterface

// File: rtl/turn_arbiter.sv
// Two-player turn controller: clamps moves, rejects collisions, forfeits on idle, strobes the points.
// Latency: req sampled -> grant next cycle -> pt_update two cycles after grant; only req[turn] is ever accepted.
module turn_arbiter #(
    parameter int MAX_TURNS = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic          update,
    input  logic          rst,
    turn_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT, S_CALC, S_SETUP, S_PULSE, S_ADV, S_DONE
    } state_t;

    state_t          r_state;
    logic            r_pt_rst;
    logic [1:0]      r_pt_en;
    logic [1:0]      r_pt_update;
    logic [2:0]      r_xmove;
    logic [2:0]      r_ymove;
    logic [1:0]      r_grant;
    logic            r_turn;
    logic [4:0]      r_turn_cnt;
    logic            r_collide;
    logic            r_done;
    logic [7:0]      r_timer;
    logic [2:0]      r_dx_req;
    logic [2:0]      r_dy_req;
    logic [2:0]      r_tx;
    logic [2:0]      r_ty;
    logic [1:0][2:0] r_x;
    logic [1:0][2:0] r_y;

    logic [2:0] w_px, w_py, w_ox, w_oy, w_tx, w_ty;
    logic       w_col;

    // Target clamped to 1..5; positive sums use a 4-bit add so 5+3 cannot wrap.
    function automatic logic [2:0] clamp_target(input logic [2:0] p, input logic [2:0] d);
        logic [3:0] sum;
        logic [2:0] m;
        sum = {1'b0, p} + {1'b0, d};
        m   = ~d + 3'd1;
        if (!d[2])
            clamp_target = (sum > 4'd5) ? 3'd5 : sum[2:0];
        else
            clamp_target = (p <= m) ? 3'd1 : p - m;
    endfunction

    assign w_px  = r_x[r_turn];
    assign w_py  = r_y[r_turn];
    assign w_ox  = r_x[~r_turn];
    assign w_oy  = r_y[~r_turn];
    assign w_tx  = clamp_target(w_px, r_dx_req);
    assign w_ty  = clamp_target(w_py, r_dy_req);
    assign w_col = (w_tx == w_ox) && (w_ty == w_oy);

    always_ff @(posedge update) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pt_rst    <= 1'b1;
            r_pt_en     <= '0;
            r_pt_update <= '0;
            r_xmove     <= '0;
            r_ymove     <= '0;
            r_grant     <= '0;
            r_turn      <= 1'b0;
            r_turn_cnt  <= '0;
            r_collide   <= 1'b0;
            r_done      <= 1'b0;
            r_timer     <= '0;
            r_dx_req    <= '0;
            r_dy_req    <= '0;
            r_tx        <= '0;
            r_ty        <= '0;
            r_x         <= {3'd4, 3'd2};
            r_y         <= {3'd2, 3'd4};
        end else begin
            r_grant     <= '0;
            r_pt_update <= '0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // Reload on entry so the INIT cycle already shows the start positions.
                    if (bus.start) begin
                        r_state    <= S_INIT;
                        r_pt_rst   <= 1'b1;
                        r_done     <= 1'b0;
                        r_turn     <= 1'b0;
                        r_turn_cnt <= '0;
                        r_collide  <= 1'b0;
                        r_timer    <= '0;
                        r_x        <= {3'd4, 3'd2};
                        r_y        <= {3'd2, 3'd4};
                    end
                end
                S_INIT: begin
                    r_pt_rst <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.req[r_turn]) begin
                        r_grant  <= 2'b01 << r_turn;
                        r_dx_req <= r_turn ? bus.xMove1 : bus.xMove0;
                        r_dy_req <= r_turn ? bus.yMove1 : bus.yMove0;
                        r_state  <= S_CALC;
                    end else if (r_timer == 8'(TIMEOUT - 1)) begin
                        r_collide <= 1'b0;
                        r_state   <= S_ADV;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_CALC: begin
                    if (w_col) begin
                        r_collide <= 1'b1;
                        r_state   <= S_ADV;
                    end else begin
                        r_collide <= 1'b0;
                        r_tx      <= w_tx;
                        r_ty      <= w_ty;
                        r_xmove   <= w_tx - w_px;
                        r_ymove   <= w_ty - w_py;
                        r_pt_en   <= 2'b01 << r_turn;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_pt_update    <= r_pt_en;
                    r_x[r_turn]    <= r_tx;
                    r_y[r_turn]    <= r_ty;
                    r_state        <= S_PULSE;
                end
                S_PULSE: begin
                    r_pt_en <= '0;
                    r_xmove <= '0;
                    r_ymove <= '0;
                    r_state <= S_ADV;
                end
                S_ADV: begin
                    r_turn     <= ~r_turn;
                    r_turn_cnt <= r_turn_cnt + 5'd1;
                    r_timer    <= '0;
                    if (r_turn_cnt + 5'd1 == 5'(MAX_TURNS)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pt_rst    = r_pt_rst;
    assign bus.pt_en     = r_pt_en;
    assign bus.pt_update = r_pt_update;
    assign bus.xMove     = r_xmove;
    assign bus.yMove     = r_ymove;
    assign bus.grant     = r_grant;
    assign bus.turn      = r_turn;
    assign bus.turn_cnt  = r_turn_cnt;
    assign bus.collide   = r_collide;
    assign bus.x0        = r_x[0];
    assign bus.y0        = r_y[0];
    assign bus.x1        = r_x[1];
    assign bus.y1        = r_y[1];
    assign bus.done      = r_done;
endmodule

// File: tb/tb_turn_arbiter.sv
// Directed bench for turn_arbiter: expected strobes queued at request time, popped when pt_update fires.
module tb_turn_arbiter;
    localparam int MT = 6;
    localparam int TO = 8;

    typedef struct {
        logic [1:0] upd;
        logic [2:0] dx;
        logic [2:0] dy;
        logic [2:0] nx;
        logic [2:0] ny;
    } exp_t;

    logic update = 1'b0;
    logic rst    = 1'b0;
    turn_arbiter_if bus ();

    turn_arbiter #(.MAX_TURNS(MT), .TIMEOUT(TO)) dut (
        .update (update),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 update = ~update;

    int   n_vec = 0;
    int   n_bad = 0;
    int   sx[2];
    int   sy[2];
    int   m_cnt;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge update);
        #1;
    endtask

    task automatic model_reset;
        sx[0] = 2; sy[0] = 4; sx[1] = 4; sy[1] = 2;
        m_cnt = 0;
    endtask

    task automatic chk_pos(input string tag);
        chk(tag, {20'd0, bus.x0, bus.y0, bus.x1, bus.y1},
                 {20'd0, 3'(sx[0]), 3'(sy[0]), 3'(sx[1]), 3'(sy[1])});
    endtask

    // Player p requests (dx,dy); both req bits are raised to show the idle player is ignored.
    task automatic move(input int p, input int dx, input int dy);
        int         tx, ty;
        bit         col, flipped;
        exp_t       e;
        logic [1:0] prev_en;
        logic [2:0] prev_xm, prev_ym;
        tx = sx[p] + dx; if (tx > 5) tx = 5; if (tx < 1) tx = 1;
        ty = sy[p] + dy; if (ty > 5) ty = 5; if (ty < 1) ty = 1;
        col = (tx == sx[1-p]) && (ty == sy[1-p]);
        if (!col) begin
            e.upd = 2'(1 << p);
            e.dx  = 3'(tx - sx[p]);
            e.dy  = 3'(ty - sy[p]);
            e.nx  = 3'(tx);
            e.ny  = 3'(ty);
            q.push_back(e);
        end
        if (p == 0) begin bus.xMove0 = 3'(dx); bus.yMove0 = 3'(dy); end
        else        begin bus.xMove1 = 3'(dx); bus.yMove1 = 3'(dy); end
        bus.req = 2'b11;
        tick;
        bus.req = 2'b00;
        chk("grant", {30'd0, bus.grant}, 32'(1 << p));
        prev_en = bus.pt_en; prev_xm = bus.xMove; prev_ym = bus.yMove;
        flipped = 1'b0;
        for (int i = 0; i < 10 && !flipped; i++) begin
            tick;
            if (bus.pt_update != 2'b00) begin
                if (q.size() == 0) begin
                    chk("spurious_strobe", {30'd0, bus.pt_update}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("pt_update", {30'd0, bus.pt_update}, {30'd0, e.upd});
                    chk("pt_en_before", {30'd0, prev_en}, {30'd0, e.upd});
                    chk("pt_en_during", {30'd0, bus.pt_en}, {30'd0, e.upd});
                    chk("moves_before", {26'd0, prev_xm, prev_ym}, {26'd0, e.dx, e.dy});
                    chk("moves_during", {26'd0, bus.xMove, bus.yMove}, {26'd0, e.dx, e.dy});
                    chk("shadow_at_strobe", p ? {26'd0, bus.x1, bus.y1} : {26'd0, bus.x0, bus.y0},
                        {26'd0, e.nx, e.ny});
                end
            end
            prev_en = bus.pt_en; prev_xm = bus.xMove; prev_ym = bus.yMove;
            if (bus.turn != 1'(p)) flipped = 1'b1;
        end
        chk("turn_passed", {31'd0, flipped}, 32'd1);
        if (!col) begin sx[p] = tx; sy[p] = ty; end
        m_cnt++;
        chk("turn_cnt", {27'd0, bus.turn_cnt}, 32'(m_cnt));
        chk("collide", {31'd0, bus.collide}, {31'd0, col});
        chk("strobes_pending", 32'(q.size()), 32'd0);
        q.delete();
        chk("pt_en_after", {30'd0, bus.pt_en}, 32'd0);
        chk_pos("shadows_after_turn");
    endtask

    task automatic idle_turn(input int p);
        int ticks;
        bit strobe, flipped;
        strobe = 1'b0; flipped = 1'b0; ticks = 0;
        for (int i = 0; i < TO + 10 && !flipped; i++) begin
            tick;
            ticks++;
            if (bus.pt_update != 2'b00) strobe = 1'b1;
            if (bus.turn != 1'(p)) flipped = 1'b1;
        end
        m_cnt++;
        chk("timeout_flip", {31'd0, flipped}, 32'd1);
        chk("timeout_cycles", 32'(ticks), 32'(TO + 1));
        chk("timeout_no_strobe", {31'd0, strobe}, 32'd0);
        chk("timeout_cnt", {27'd0, bus.turn_cnt}, 32'(m_cnt));
        chk("timeout_collide", {31'd0, bus.collide}, 32'd0);
        chk_pos("timeout_shadows");
    endtask

    initial begin
        bus.start = 1'b0; bus.req = 2'b00;
        bus.xMove0 = '0; bus.yMove0 = '0; bus.xMove1 = '0; bus.yMove1 = '0;
        model_reset();
        rst = 1'b0;
        tick; tick;
        chk("rst_pt_rst", {31'd0, bus.pt_rst}, 32'd1);
        chk("rst_outputs", {19'd0, bus.pt_en, bus.pt_update, bus.grant, bus.turn, bus.turn_cnt, bus.done},
            32'd0);
        chk_pos("rst_shadows");

        rst = 1'b1; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("init_pt_rst", {31'd0, bus.pt_rst}, 32'd1);
        tick;
        chk("wait_pt_rst", {31'd0, bus.pt_rst}, 32'd0);
        chk("wait_turn", {31'd0, bus.turn}, 32'd0);

        move(0, 3, 3);     // clamp at top: (2,4) -> (5,5), delta (+3,+1)
        move(1, -4, -3);   // p <= m clamp: (4,2) -> (1,1), delta (-3,-1)
        move(0, 0, 0);     // legal zero move
        idle_turn(1);
        move(0, -4, -4);   // (5,5) -> (1,1) lands on player 1
        move(1, 1, 0);     // final turn
        chk("done_set", {31'd0, bus.done}, 32'd1);

        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        model_reset();
        chk("restart_init", {26'd0, bus.pt_rst, bus.done, bus.turn, bus.turn_cnt[2:0]}, 32'h20);
        chk_pos("restart_shadows");
        tick;

        move(0, 2, -2);    // (2,4) -> (4,2) collides with player 1

        bus.xMove1 = 3'd0; bus.yMove1 = 3'd1; bus.req = 2'b10;
        tick;
        bus.req = 2'b00;
        tick;
        chk("setup_en", {30'd0, bus.pt_en}, 32'd2);
        tick;
        chk("pulse_upd", {30'd0, bus.pt_update}, 32'd2);
        chk("pulse_shadow", {29'd0, bus.y1}, 32'd3);
        rst = 1'b0;
        tick;
        model_reset();
        chk("midpulse_rst", {27'd0, bus.pt_rst, bus.pt_update, bus.pt_en}, 32'h10);
        chk("midpulse_state", {24'd0, bus.turn, bus.turn_cnt, bus.collide, bus.done}, 32'd0);
        chk_pos("midpulse_shadows");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/turn_arbiter.md
Name: turn_arbiter

Overview:
- Two-player turn controller for the pair of grid points on the 5x5 board (coordinates 1..5).
- Alternates turns between player 0 and player 1, and accepts each player's move request.
- Pre-clamps each move so that the point's own arithmetic never saturates, rejects moves that would land on the other point, and forfeits a turn if the player does not respond in time.
- Drives the points' update/en/rst/move inputs and keeps shadow copies of both positions.

Parameters:
- MAX_TURNS, 16, total turns (moved, rejected or forfeited) before DONE; range 1..31.
- TIMEOUT, 255, cycles a player may idle in WAIT before the turn is forfeited; range 1..255.

Ports:
- update  in   1  system clock; all logic is on the rising edge.
- rst     in   1  synchronous active-low reset.
- start   in   1  begins a game from IDLE or DONE.
- req     in   2  req[p]=1: player p presents a move.
- xMove0  in   3  player 0 x move, two's complement, -4..3.
- yMove0  in   3  player 0 y move.
- xMove1  in   3  player 1 x move.
- yMove1  in   3  player 1 y move.
- pt_rst     out  1  active-high reset to both point instances.
- pt_en      out  2  enable to point p.
- pt_update  out  2  one-cycle strobe to point p's update input.
- xMove      out  3  clamped x delta to the points, two's complement.
- yMove      out  3  clamped y delta to the points.
- grant      out  2  one-cycle pulse: the request of player p was accepted.
- turn       out  1  player whose turn it is.
- turn_cnt   out  5  turns completed.
- collide    out  1  the last accepted move was rejected.
- x0, y0, x1, y1  out  3 each  shadow positions.
- done       out  1  game over.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at an edge):
  - state=IDLE, pt_rst=1, all other outputs 0.
  - Shadows are set to x0=2, y0=4, x1=4, y1=2.
  - Reset overrides any state, including a strobe in progress.
- States:
  - IDLE: pt_rst=1. start=1 -> INIT.
  - INIT (1 cycle):
    - pt_rst=1; shadows reload to (2,4) and (4,2).
    - turn=0, turn_cnt=0, collide=0, timer=0.
    - Next state: WAIT.
  - WAIT: pt_rst=0.
    - If req[turn]=1: latch that player's xMove/yMove, pulse grant[turn] (next cycle), go to CALC.
    - req of the other player is ignored.
    - If timer reaches TIMEOUT-1 without a request: forfeit the turn and go to ADV. Shadows are unchanged and collide=0.
  - CALC (1 cycle): compute the target per axis.
    - Positive d: t = min(p+d, 5). Sums are computed at 4 bits; no 3-bit wrap.
    - Negative d, with m = -d (1..4): t = (p <= m) ? 1 : p-m.
    - Zero d: t = p.
    - out delta = t - p, always within -4..3.
    - Collision: if (tx,ty) equals the other player's shadow position, set collide=1 and go to ADV with no strobe.
    - Otherwise set collide=0 and go to SETUP.
  - SETUP (1 cycle): pt_en[turn]=1 and xMove/yMove driven; pt_update=0.
  - PULSE (1 cycle):
    - pt_update[turn]=1, with pt_en and the moves held.
    - The mover's shadow takes (tx,ty).
    - Next state: ADV.
  - ADV (1 cycle):
    - pt_en, pt_update and the moves return to 0.
    - turn toggles, turn_cnt increments, timer is cleared.
    - If turn_cnt+1 == MAX_TURNS go to DONE, else go to WAIT.
  - DONE: done=1; the points are held at their final positions. start=1 -> INIT, with done cleared.
- Timing:
  - Latency from a request sampled in WAIT to the pt_update rising edge is 3 cycles.
  - The moves and pt_en are stable 1 cycle before and during the strobe.
  - Only one bit of pt_update or pt_en is ever high at a time.
- start is ignored outside IDLE and DONE.
- A zero move (0,0) on a square not occupied by the other player is legal and strobes normally.
- Because the points apply the delta exactly, the shadows always equal the points' x/y after each strobe.

Test Plan:
- Reset then start -> pt_rst high through INIT; shadows (2,4)/(4,2); turn=0; done=0.
- P0 req with x=+3, y=+3 -> grant[0] pulses; 3 cycles later pt_update[0]=1 with xMove=+3 (011) and yMove=+1 (001); x0=5, y0=5; turn=1.
- P1 at (4,2) requests x=-4, y=-3 -> delta (-3,-1); shadow (1,1). This checks the p<=m clamp to 1.
- P0 at (2,4) moves to land on (4,2), x=+2, y=-2 -> collide=1; no pt_update; shadows unchanged; turn passes.
- No req for TIMEOUT cycles -> turn toggles, turn_cnt increments, no strobe. After MAX_TURNS turns, done=1; a later start -> INIT.
- rst=0 asserted during PULSE -> next cycle IDLE, pt_rst=1, pt_update=0, shadows back to their initial values.
